// File: rtl/bypass_pkg.sv
// Shared types and defaults for the decode-stage operand bypass.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package bypass_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int NUM_RD_DEF  = 2;
    localparam int DEPTH_DEF   = 3;
    localparam int ALU_RDY_DEF = 1;
    localparam int LD_RDY_DEF  = 2;

    // Architectural zero register: never tracked, never forwarded.
    localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;

    // One in-flight producer. dst width is fixed by the package, so the
    // top-level REG_AW must stay equal to REG_AW_DEF.
    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] dst;
        logic                  ld;
    } entry_t;

    // A producer in stage k has its result once it reaches its ready stage.
    function automatic logic is_ready(input int k, input logic ld,
                                      input int alu_rdy, input int ld_rdy);
        return (k >= (ld ? ld_rdy : alu_rdy));
    endfunction

endpackage

// File: rtl/operand_bypass_unit_if.sv
// Decode-side bundle: issue info, read addresses, candidate data, bypass results.
// Latency: n/a (wires only).
// Backpressure: stall_d flows back toward decode.
interface operand_bypass_unit_if #(
    parameter int DATA_W = bypass_pkg::DATA_W_DEF,
    parameter int REG_AW = bypass_pkg::REG_AW_DEF,
    parameter int NUM_RD = bypass_pkg::NUM_RD_DEF,
    parameter int DEPTH  = bypass_pkg::DEPTH_DEF
) ();
    logic                     issue_valid;
    logic                     issue_we;
    logic [REG_AW-1:0]        issue_dst;
    logic                     issue_ld;
    logic                     flush_e;
    logic [NUM_RD*REG_AW-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rf_rdata;
    logic [DEPTH*DATA_W-1:0]  stage_data;
    logic [NUM_RD*DATA_W-1:0] opnd;
    logic [NUM_RD-1:0]        fwd_hit;
    logic                     stall_d;

    modport master (
        output issue_valid, issue_we, issue_dst, issue_ld, flush_e,
               rd_addr, rf_rdata, stage_data,
        input  opnd, fwd_hit, stall_d
    );

    modport slave (
        input  issue_valid, issue_we, issue_dst, issue_ld, flush_e,
               rd_addr, rf_rdata, stage_data,
        output opnd, fwd_hit, stall_d
    );
endinterface

// File: rtl/bypass_port.sv
// One read port: picks the youngest in-flight producer of rd_addr, else RF data.
// Latency: 0 (purely combinational).
// Backpressure: need_stall when the youngest producer has no result yet.
module bypass_port
    import bypass_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ALU_RDY = ALU_RDY_DEF,
    parameter int LD_RDY  = LD_RDY_DEF
) (
    input  entry_t [DEPTH-1:0]      ent_i,
    input  logic [DEPTH*DATA_W-1:0] stage_data_i,
    input  logic [REG_AW_DEF-1:0]   rd_addr_i,
    input  logic [DATA_W-1:0]       rf_rdata_i,
    output logic [DATA_W-1:0]       opnd_o,
    output logic                    fwd_hit_o,
    output logic                    need_stall_o
);

    // Scan oldest to youngest so the youngest match overrides; an unready
    // youngest match hides any older ready one.
    always_comb begin
        opnd_o       = rf_rdata_i;
        fwd_hit_o    = 1'b0;
        need_stall_o = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_i[k].valid && (ent_i[k].dst == rd_addr_i) && (rd_addr_i != REG_ZERO)) begin
                if (is_ready(k, ent_i[k].ld, ALU_RDY, LD_RDY)) begin
                    opnd_o       = stage_data_i[k*DATA_W +: DATA_W];
                    fwd_hit_o    = 1'b1;
                    need_stall_o = 1'b0;
                end else begin
                    opnd_o       = rf_rdata_i;
                    fwd_hit_o    = 1'b0;
                    need_stall_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/operand_bypass_unit.sv
// Decode operand bypass with in-flight destination tracking; BYPASS_PERF_EN adds stall/forward counters.
// Latency: 0 from rd_addr to opnd; tracking entries advance every clock.
// Backpressure: stall_d holds decode and injects a bubble; older entries keep draining.
module operand_bypass_unit
    import bypass_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_RD  = NUM_RD_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ALU_RDY = ALU_RDY_DEF,
    parameter int LD_RDY  = LD_RDY_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    operand_bypass_unit_if.slave   bus
`ifdef BYPASS_PERF_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_fwd_cnt
`endif
);

    entry_t [DEPTH-1:0]             ent_q;
    entry_t                         ent0_d;
    logic [NUM_RD-1:0][DATA_W-1:0]  opnd_w;
    logic [NUM_RD-1:0]              hit_w;
    logic [NUM_RD-1:0]              need_stall_w;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        bypass_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ALU_RDY (ALU_RDY),
            .LD_RDY  (LD_RDY)
        ) u_port (
            .ent_i        (ent_q),
            .stage_data_i (bus.stage_data),
            .rd_addr_i    (bus.rd_addr[p*REG_AW +: REG_AW]),
            .rf_rdata_i   (bus.rf_rdata[p*DATA_W +: DATA_W]),
            .opnd_o       (opnd_w[p]),
            .fwd_hit_o    (hit_w[p]),
            .need_stall_o (need_stall_w[p])
        );
    end

    assign bus.opnd    = opnd_w;
    assign bus.fwd_hit = hit_w;
    assign bus.stall_d = |need_stall_w;

    // New producer enters E only if it really issues and writes a non-zero register.
    always_comb begin
        ent0_d.valid = bus.issue_valid & bus.issue_we & (bus.issue_dst != REG_ZERO)
                     & ~bus.stall_d & ~bus.flush_e;
        ent0_d.dst   = bus.issue_dst;
        ent0_d.ld    = bus.issue_ld;
    end

    // Tracking shift register: never frozen, oldest entry retires each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q <= '0;
        end else begin
            ent_q[0] <= ent0_d;
            for (int k = 1; k < DEPTH; k++) begin
                ent_q[k] <= ent_q[k-1];
            end
        end
    end

`ifdef BYPASS_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    // Saturating event counts: stalled cycles and cycles that used a forward.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (bus.stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((|bus.fwd_hit) && !bus.stall_d && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Scoreboard bench for operand_bypass_unit: expected outputs queued at drive time, popped at negedge.
module tb_operand_bypass_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DP = 3;

    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_1111;
    localparam logic [31:0] S0  = 32'h0E0E_0E0E;
    localparam logic [31:0] S1  = 32'h0000_1234;
    localparam logic [31:0] S2  = 32'h0000_CAFE;
    localparam logic [63:0] RF     = {RF1, RF0};
    localparam logic [63:0] M_ALL  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M_P1   = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] M_NONE = 64'h0;

    typedef struct {
        logic       iv, we, ld, fl;
        logic [4:0] dst, a0, a1;
    } stim_t;

    typedef struct {
        logic        stall;
        logic [1:0]  hit;
        logic [63:0] opnd;
        logic [63:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_bypass_unit_if #(.DATA_W(DW), .REG_AW(AW), .NUM_RD(NR), .DEPTH(DP)) bus ();

`ifdef BYPASS_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;
`endif

    operand_bypass_unit #(
        .DATA_W(DW), .REG_AW(AW), .NUM_RD(NR), .DEPTH(DP), .ALU_RDY(1), .LD_RDY(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef BYPASS_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
`endif
    );

    exp_t sb[$];
    int   nvec = 0;
    int   nfail = 0;
    int   exp_st = 0;
    int   exp_fw = 0;

    function automatic stim_t mk_s(logic iv, logic we, logic [4:0] dst, logic ld, logic fl,
                                   logic [4:0] a0, logic [4:0] a1);
        stim_t s;
        s.iv = iv; s.we = we; s.dst = dst; s.ld = ld; s.fl = fl; s.a0 = a0; s.a1 = a1;
        return s;
    endfunction

    function automatic exp_t mk_e(logic st, logic [1:0] hit, logic [63:0] op, logic [63:0] m);
        exp_t e;
        e.stall = st; e.hit = hit; e.opnd = op; e.mask = m;
        return e;
    endfunction

    task automatic drive_idle();
        bus.issue_valid = 1'b0;
        bus.issue_we    = 1'b0;
        bus.issue_dst   = '0;
        bus.issue_ld    = 1'b0;
        bus.flush_e     = 1'b0;
        bus.rd_addr     = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_idle();
        end
    endtask

    // Drive one decode cycle and queue what the outputs must be during it.
    task automatic apply(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        bus.issue_valid = s.iv;
        bus.issue_we    = s.we;
        bus.issue_dst   = s.dst;
        bus.issue_ld    = s.ld;
        bus.flush_e     = s.fl;
        bus.rd_addr     = {s.a1, s.a0};
        sb.push_back(e);
        if (e.stall) exp_st++;
        else if (e.hit != 2'b00) exp_fw++;
    endtask

    task automatic test_reset();
        exp_t x;
        reset = 1'b1;
        drive_idle();
        bus.rf_rdata   = RF;
        bus.stage_data = {S2, S1, S0};
        bus.rd_addr    = {5'd3, 5'd3};
        sb.push_back(mk_e(1'b0, 2'b00, RF, M_ALL));
        @(negedge clk);
        x = sb.pop_front();
        nvec++; if (bus.stall_d !== x.stall) begin nfail++; $display("FAIL reset stall_d got %0b want %0b", bus.stall_d, x.stall); end
        nvec++; if (bus.fwd_hit !== x.hit) begin nfail++; $display("FAIL reset fwd_hit got %b want %b", bus.fwd_hit, x.hit); end
        nvec++; if (bus.opnd !== x.opnd) begin nfail++; $display("FAIL reset opnd got %h want %h", bus.opnd, x.opnd); end
`ifdef BYPASS_PERF_EN
        nvec++; if (perf_stall_cnt !== 32'd0) begin nfail++; $display("FAIL reset perf_stall_cnt got %0d want 0", perf_stall_cnt); end
        nvec++; if (perf_fwd_cnt !== 32'd0) begin nfail++; $display("FAIL reset perf_fwd_cnt got %0d want 0", perf_fwd_cnt); end
`endif
        drive_idle();
        reset = 1'b0;
    endtask

    // ADD r3, then read r3: one stall while it sits in E, then forwarded from M.
    task automatic test_alu_fwd();
        stim_t s[3]; exp_t e[3]; exp_t x;
        s[0] = mk_s(1, 1, 5'd3, 0, 0, 5'd0, 5'd0); e[0] = mk_e(0, 2'b00, RF, M_ALL);
        s[1] = mk_s(0, 0, 5'd0, 0, 0, 5'd3, 5'd3); e[1] = mk_e(1, 2'b00, RF, M_NONE);
        s[2] = mk_s(0, 0, 5'd0, 0, 0, 5'd3, 5'd3); e[2] = mk_e(0, 2'b11, {S1, S1}, M_ALL);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            nvec++; if (bus.stall_d !== x.stall) begin nfail++; $display("FAIL alu_fwd[%0d] stall_d got %0b want %0b", i, bus.stall_d, x.stall); end
            nvec++; if (bus.fwd_hit !== x.hit) begin nfail++; $display("FAIL alu_fwd[%0d] fwd_hit got %b want %b", i, bus.fwd_hit, x.hit); end
            if (x.mask != M_NONE) begin
                nvec++; if ((bus.opnd & x.mask) !== (x.opnd & x.mask)) begin nfail++; $display("FAIL alu_fwd[%0d] opnd got %h want %h", i, bus.opnd & x.mask, x.opnd & x.mask); end
            end
        end
    endtask

    // LW r5 then a reader of r5 that writes r6: two stall cycles, bubbles only.
    task automatic test_load_use();
        stim_t s[6]; exp_t e[6]; exp_t x;
        s[0] = mk_s(1, 1, 5'd5, 1, 0, 5'd0, 5'd0); e[0] = mk_e(0, 2'b00, RF, M_ALL);
        s[1] = mk_s(1, 1, 5'd6, 0, 0, 5'd5, 5'd6); e[1] = mk_e(1, 2'b00, RF, M_P1);
        s[2] = mk_s(1, 1, 5'd6, 0, 0, 5'd5, 5'd6); e[2] = mk_e(1, 2'b00, RF, M_P1);
        s[3] = mk_s(1, 1, 5'd6, 0, 0, 5'd5, 5'd6); e[3] = mk_e(0, 2'b01, {RF1, S2}, M_ALL);
        s[4] = mk_s(0, 0, 5'd0, 0, 0, 5'd6, 5'd5); e[4] = mk_e(1, 2'b00, RF, M_P1);
        s[5] = mk_s(0, 0, 5'd0, 0, 0, 5'd6, 5'd0); e[5] = mk_e(0, 2'b01, {RF1, S1}, M_ALL);
        idle(3);
        for (int i = 0; i < 6; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            nvec++; if (bus.stall_d !== x.stall) begin nfail++; $display("FAIL load_use[%0d] stall_d got %0b want %0b", i, bus.stall_d, x.stall); end
            nvec++; if (bus.fwd_hit !== x.hit) begin nfail++; $display("FAIL load_use[%0d] fwd_hit got %b want %b", i, bus.fwd_hit, x.hit); end
            if (x.mask != M_NONE) begin
                nvec++; if ((bus.opnd & x.mask) !== (x.opnd & x.mask)) begin nfail++; $display("FAIL load_use[%0d] opnd got %h want %h", i, bus.opnd & x.mask, x.opnd & x.mask); end
            end
        end
    endtask

    // ADD r4 then SUB r4: unready SUB hides the ready ADD, then SUB wins from M.
    task automatic test_youngest();
        stim_t s[4]; exp_t e[4]; exp_t x;
        s[0] = mk_s(1, 1, 5'd4, 0, 0, 5'd0, 5'd0); e[0] = mk_e(0, 2'b00, RF, M_ALL);
        s[1] = mk_s(1, 1, 5'd4, 0, 0, 5'd0, 5'd0); e[1] = mk_e(0, 2'b00, RF, M_ALL);
        s[2] = mk_s(0, 0, 5'd0, 0, 0, 5'd4, 5'd4); e[2] = mk_e(1, 2'b00, RF, M_NONE);
        s[3] = mk_s(0, 0, 5'd0, 0, 0, 5'd4, 5'd4); e[3] = mk_e(0, 2'b11, {S1, S1}, M_ALL);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            nvec++; if (bus.stall_d !== x.stall) begin nfail++; $display("FAIL youngest[%0d] stall_d got %0b want %0b", i, bus.stall_d, x.stall); end
            nvec++; if (bus.fwd_hit !== x.hit) begin nfail++; $display("FAIL youngest[%0d] fwd_hit got %b want %b", i, bus.fwd_hit, x.hit); end
            if (x.mask != M_NONE) begin
                nvec++; if ((bus.opnd & x.mask) !== (x.opnd & x.mask)) begin nfail++; $display("FAIL youngest[%0d] opnd got %h want %h", i, bus.opnd & x.mask, x.opnd & x.mask); end
            end
        end
    endtask

    // Load to r0 is never tracked; reading r0 returns the RF zero.
    task automatic test_r0();
        stim_t s[3]; exp_t e[3]; exp_t x;
        s[0] = mk_s(1, 1, 5'd0, 1, 0, 5'd0, 5'd0); e[0] = mk_e(0, 2'b00, 64'h0, M_ALL);
        s[1] = mk_s(0, 0, 5'd0, 0, 0, 5'd0, 5'd0); e[1] = mk_e(0, 2'b00, 64'h0, M_ALL);
        s[2] = mk_s(0, 0, 5'd0, 0, 0, 5'd0, 5'd0); e[2] = mk_e(0, 2'b00, 64'h0, M_ALL);
        idle(3);
        bus.rf_rdata = 64'h0;
        for (int i = 0; i < 3; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            nvec++; if (bus.stall_d !== x.stall) begin nfail++; $display("FAIL r0[%0d] stall_d got %0b want %0b", i, bus.stall_d, x.stall); end
            nvec++; if (bus.fwd_hit !== x.hit) begin nfail++; $display("FAIL r0[%0d] fwd_hit got %b want %b", i, bus.fwd_hit, x.hit); end
            nvec++; if ((bus.opnd & x.mask) !== (x.opnd & x.mask)) begin nfail++; $display("FAIL r0[%0d] opnd got %h want %h", i, bus.opnd & x.mask, x.opnd & x.mask); end
        end
        @(posedge clk);
        #1;
        bus.rf_rdata = RF;
        drive_idle();
    endtask

    // LW r7 squashed on entry to E: later reads of r7 go to the RF.
    task automatic test_flush();
        stim_t s[4]; exp_t e[4]; exp_t x;
        s[0] = mk_s(1, 1, 5'd7, 1, 1, 5'd0, 5'd0); e[0] = mk_e(0, 2'b00, RF, M_ALL);
        s[1] = mk_s(0, 0, 5'd0, 0, 0, 5'd7, 5'd7); e[1] = mk_e(0, 2'b00, RF, M_ALL);
        s[2] = mk_s(0, 0, 5'd0, 0, 0, 5'd7, 5'd7); e[2] = mk_e(0, 2'b00, RF, M_ALL);
        s[3] = mk_s(0, 0, 5'd0, 0, 0, 5'd7, 5'd7); e[3] = mk_e(0, 2'b00, RF, M_ALL);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            nvec++; if (bus.stall_d !== x.stall) begin nfail++; $display("FAIL flush[%0d] stall_d got %0b want %0b", i, bus.stall_d, x.stall); end
            nvec++; if (bus.fwd_hit !== x.hit) begin nfail++; $display("FAIL flush[%0d] fwd_hit got %b want %b", i, bus.fwd_hit, x.hit); end
            nvec++; if ((bus.opnd & x.mask) !== (x.opnd & x.mask)) begin nfail++; $display("FAIL flush[%0d] opnd got %h want %h", i, bus.opnd & x.mask, x.opnd & x.mask); end
        end
    endtask

    // Reset asserted while a load-use stall is active clears it immediately.
    task automatic test_reset_mid_stall();
        stim_t s[2]; exp_t e[2]; exp_t x;
        s[0] = mk_s(1, 1, 5'd5, 1, 0, 5'd0, 5'd0); e[0] = mk_e(0, 2'b00, RF, M_ALL);
        s[1] = mk_s(0, 0, 5'd0, 0, 0, 5'd5, 5'd5); e[1] = mk_e(1, 2'b00, RF, M_NONE);
        idle(3);
        for (int i = 0; i < 2; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            nvec++; if (bus.stall_d !== x.stall) begin nfail++; $display("FAIL rst_stall[%0d] stall_d got %0b want %0b", i, bus.stall_d, x.stall); end
            nvec++; if (bus.fwd_hit !== x.hit) begin nfail++; $display("FAIL rst_stall[%0d] fwd_hit got %b want %b", i, bus.fwd_hit, x.hit); end
            if (x.mask != M_NONE) begin
                nvec++; if ((bus.opnd & x.mask) !== (x.opnd & x.mask)) begin nfail++; $display("FAIL rst_stall[%0d] opnd got %h want %h", i, bus.opnd & x.mask, x.opnd & x.mask); end
            end
`ifdef BYPASS_PERF_EN
            if (i == 0) begin
                nvec++; if (perf_stall_cnt !== 32'(exp_st)) begin nfail++; $display("FAIL perf_stall_cnt got %0d want %0d", perf_stall_cnt, exp_st); end
                nvec++; if (perf_fwd_cnt !== 32'(exp_fw)) begin nfail++; $display("FAIL perf_fwd_cnt got %0d want %0d", perf_fwd_cnt, exp_fw); end
            end
`endif
        end
        #1;
        reset = 1'b1;
        sb.push_back(mk_e(0, 2'b00, RF, M_ALL));
        #1;
        x = sb.pop_front();
        nvec++; if (bus.stall_d !== x.stall) begin nfail++; $display("FAIL rst_now stall_d got %0b want %0b", bus.stall_d, x.stall); end
        nvec++; if (bus.fwd_hit !== x.hit) begin nfail++; $display("FAIL rst_now fwd_hit got %b want %b", bus.fwd_hit, x.hit); end
        nvec++; if (bus.opnd !== x.opnd) begin nfail++; $display("FAIL rst_now opnd got %h want %h", bus.opnd, x.opnd); end
`ifdef BYPASS_PERF_EN
        nvec++; if (perf_stall_cnt !== 32'd0) begin nfail++; $display("FAIL rst_now perf_stall_cnt got %0d want 0", perf_stall_cnt); end
        nvec++; if (perf_fwd_cnt !== 32'd0) begin nfail++; $display("FAIL rst_now perf_fwd_cnt got %0d want 0", perf_fwd_cnt); end
`endif
        @(negedge clk);
        reset = 1'b0;
        apply(mk_s(0, 0, 5'd0, 0, 0, 5'd5, 5'd5), mk_e(0, 2'b00, RF, M_ALL));
        @(negedge clk);
        x = sb.pop_front();
        nvec++; if (bus.stall_d !== x.stall) begin nfail++; $display("FAIL rst_after stall_d got %0b want %0b", bus.stall_d, x.stall); end
        nvec++; if (bus.fwd_hit !== x.hit) begin nfail++; $display("FAIL rst_after fwd_hit got %b want %b", bus.fwd_hit, x.hit); end
        nvec++; if (bus.opnd !== x.opnd) begin nfail++; $display("FAIL rst_after opnd got %h want %h", bus.opnd, x.opnd); end
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_r0();
        test_flush();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
